// File: rtl/ram_sdp_be_if.sv
// Bus bundle for the simple dual-port RAM: write port, read port and status strobes.
// The master drives requests, the slave (the RAM) drives read data and status.
interface ram_sdp_be_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wbe;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  busy;
    logic                  err;

    modport master (
        output we, waddr, wdata, wbe, re, raddr,
        input  rdata, rvalid, busy, err
    );

    modport slave (
        input  we, waddr, wdata, wbe, re, raddr,
        output rdata, rvalid, busy, err
    );
endinterface

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset clear sequencer.
module ram_sdp_be #(
    parameter int                        ADDR_WIDTH = 3,
    parameter int                        DATA_WIDTH = 8,
    parameter int                        DEPTH      = 8,
    parameter int                        RD_LATENCY = 1,
    parameter int                        RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    ram_sdp_be_if.slave  bus
);
    localparam int                    NB      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_req;
    logic                    rd_req;
    logic                    wr_oor;
    logic                    rd_oor;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    p_valid;
    logic                    p_err;
    logic [DATA_WIDTH-1:0]   p_data;

    logic                    out_valid;
    logic                    out_err;
    logic [DATA_WIDTH-1:0]   out_data;

    // Requests only count once the clear has finished; the compare is one bit wider
    // so DEPTH == 2**ADDR_WIDTH never flags an address as out of range.
    always_comb begin
        wr_oor  = {1'b0, bus.waddr} >= DEPTH_W;
        rd_oor  = {1'b0, bus.raddr} >= DEPTH_W;
        wr_req  = (state == READY) && bus.we;
        rd_req  = (state == READY) && bus.re;
        rd_word = '0;
        if (!rd_oor) begin
            rd_word = mem[bus.raddr];
            if (RDW_MODE == 1 && wr_req && bus.waddr == bus.raddr) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.wbe[i]) begin
                        rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        out_valid = rd_req;
        out_err   = rd_req && rd_oor;
        out_data  = rd_word;
        if (RD_LATENCY == 2) begin
            out_valid = p_valid;
            out_err   = p_err;
            out_data  = p_data;
        end
    end

    // Storage has no reset; the clear sequencer owns the write port until READY.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !rst) begin
            mem[clr_ptr] <= CLEAR_VAL;
        end else if (wr_req && !wr_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            bus.busy   <= 1'b1;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            p_valid    <= 1'b0;
            p_err      <= 1'b0;
            p_data     <= '0;
        end else begin
            if (state == CLEAR) begin
                if (clr_ptr == LAST) begin
                    state    <= READY;
                    bus.busy <= 1'b0;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                end
            end
            p_valid <= rd_req;
            p_err   <= rd_req && rd_oor;
            if (rd_req) begin
                p_data <= rd_word;
            end
            // A write error is always one cycle late; a read error tracks its rvalid.
            bus.rvalid <= out_valid;
            bus.err    <= (wr_req && wr_oor) || out_err;
            if (out_valid) begin
                bus.rdata <= out_data;
            end
        end
    end
endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: four instances cover the default, 32-bit write-first,
// short-depth and two-cycle-latency configurations.
module tb_ram_sdp_be;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ram_sdp_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8))  ia ();
    ram_sdp_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) ib ();
    ram_sdp_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8))  ic ();
    ram_sdp_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8))  id ();

    ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(8), .RD_LATENCY(1), .RDW_MODE(0))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .RD_LATENCY(1), .RDW_MODE(1))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(6), .RD_LATENCY(1), .RDW_MODE(0))
        u_c (.clk(clk), .rst(rst), .bus(ic));
    ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(8), .RD_LATENCY(2), .RDW_MODE(0))
        u_d (.clk(clk), .rst(rst), .bus(id));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        ia.we = 1'b0; ia.waddr = '0; ia.wdata = '0; ia.wbe = '0; ia.re = 1'b0; ia.raddr = '0;
        ib.we = 1'b0; ib.waddr = '0; ib.wdata = '0; ib.wbe = '0; ib.re = 1'b0; ib.raddr = '0;
        ic.we = 1'b0; ic.waddr = '0; ic.wdata = '0; ic.wbe = '0; ic.re = 1'b0; ic.raddr = '0;
        id.we = 1'b0; id.waddr = '0; id.wdata = '0; id.wbe = '0; id.re = 1'b0; id.raddr = '0;
    endtask

    task automatic test_reset;
        int cnt_a;
        int cnt_c;
        rst = 1'b1;
        idle_all();
        repeat (3) tick();
        vectors++; if (ia.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 1", ia.busy); end
        vectors++; if (ia.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b want 0", ia.rvalid); end
        vectors++; if (ia.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", ia.err); end
        vectors++; if (ia.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h want 00", ia.rdata); end
        rst = 1'b0;
        cnt_a = 0;
        cnt_c = 0;
        for (int c = 0; c < 20; c++) begin
            cnt_a += (ia.busy === 1'b1) ? 1 : 0;
            cnt_c += (ic.busy === 1'b1) ? 1 : 0;
            tick();
        end
        vectors++; if (cnt_a !== 8) begin miscompares++; $display("[TB] FAIL clear_cycles_d8: got %0d want 8", cnt_a); end
        vectors++; if (cnt_c !== 6) begin miscompares++; $display("[TB] FAIL clear_cycles_d6: got %0d want 6", cnt_c); end
        vectors++; if (ia.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_busy_a: got %b want 0", ia.busy); end
        vectors++; if (ib.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_busy_b: got %b want 0", ib.busy); end
        vectors++; if (id.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_busy_d: got %b want 0", id.busy); end
    endtask

    task automatic test_clear_reads;
        for (int a = 0; a < 8; a++) begin
            ia.re = 1'b1;
            ia.raddr = 3'(a);
            tick();
            vectors++; if (ia.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_rvalid[%0d]: got %b want 1", a, ia.rvalid); end
            vectors++; if (ia.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL clear_rdata[%0d]: got %h want 00", a, ia.rdata); end
        end
        ia.re = 1'b0;
        tick();
        vectors++; if (ia.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rvalid_strobe: got %b want 0", ia.rvalid); end
    endtask

    task automatic test_byte_enable;
        ib.we = 1'b1; ib.waddr = 3'd3; ib.wdata = 32'hAABBCCDD; ib.wbe = 4'hF;
        tick();
        vectors++; if (ib.err !== 1'b0) begin miscompares++; $display("[TB] FAIL be_full_err: got %b want 0", ib.err); end
        ib.wdata = 32'h11223344; ib.wbe = 4'b0101;
        tick();
        ib.wdata = 32'hFFFFFFFF; ib.wbe = 4'b0000;
        tick();
        vectors++; if (ib.err !== 1'b0) begin miscompares++; $display("[TB] FAIL be_zero_err: got %b want 0", ib.err); end
        ib.we = 1'b0; ib.re = 1'b1; ib.raddr = 3'd3;
        tick();
        vectors++; if (ib.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL be_rvalid: got %b want 1", ib.rvalid); end
        vectors++; if (ib.rdata !== 32'hAA22CC44) begin miscompares++; $display("[TB] FAIL be_merge: got %h want aa22cc44", ib.rdata); end
        ib.re = 1'b0;
        tick();
    endtask

    task automatic test_rdw_read_first;
        ia.we = 1'b1; ia.waddr = 3'd2; ia.wdata = 8'h55; ia.wbe = 1'b1;
        ia.re = 1'b1; ia.raddr = 3'd2;
        tick();
        vectors++; if (ia.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdw0_rvalid: got %b want 1", ia.rvalid); end
        vectors++; if (ia.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL rdw0_old: got %h want 00", ia.rdata); end
        ia.we = 1'b0;
        tick();
        vectors++; if (ia.rdata !== 8'h55) begin miscompares++; $display("[TB] FAIL rdw0_after: got %h want 55", ia.rdata); end
        ia.re = 1'b0;
        tick();
    endtask

    task automatic test_rdw_write_first;
        ib.we = 1'b1; ib.waddr = 3'd2; ib.wdata = 32'h00000055; ib.wbe = 4'hF;
        ib.re = 1'b1; ib.raddr = 3'd2;
        tick();
        vectors++; if (ib.rdata !== 32'h00000055) begin miscompares++; $display("[TB] FAIL rdw1_new: got %h want 00000055", ib.rdata); end
        ib.wdata = 32'hDEADBEEF; ib.wbe = 4'b1010;
        tick();
        vectors++; if (ib.rdata !== 32'hDE00BE55) begin miscompares++; $display("[TB] FAIL rdw1_lane_merge: got %h want de00be55", ib.rdata); end
        ib.we = 1'b0;
        tick();
        vectors++; if (ib.rdata !== 32'hDE00BE55) begin miscompares++; $display("[TB] FAIL rdw1_after: got %h want de00be55", ib.rdata); end
        ib.we = 1'b1; ib.waddr = 3'd2; ib.wdata = 32'h0; ib.wbe = 4'hF; ib.raddr = 3'd3;
        tick();
        vectors++; if (ib.rdata !== 32'hAA22CC44) begin miscompares++; $display("[TB] FAIL rdw1_other_addr: got %h want aa22cc44", ib.rdata); end
        ib.we = 1'b0; ib.re = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range;
        ic.we = 1'b1; ic.waddr = 3'd5; ic.wdata = 8'h5A; ic.wbe = 1'b1;
        tick();
        vectors++; if (ic.err !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_inrange_err: got %b want 0", ic.err); end
        ic.waddr = 3'd7; ic.wdata = 8'hFF;
        tick();
        vectors++; if (ic.err !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_write_err: got %b want 1", ic.err); end
        ic.we = 1'b0;
        tick();
        vectors++; if (ic.err !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_err_strobe: got %b want 0", ic.err); end
        for (int a = 0; a < 6; a++) begin
            ic.re = 1'b1;
            ic.raddr = 3'(a);
            tick();
            vectors++; if (ic.rdata !== ((a == 5) ? 8'h5A : 8'h00)) begin miscompares++; $display("[TB] FAIL oor_mem[%0d]: got %h want %h", a, ic.rdata, (a == 5) ? 8'h5A : 8'h00); end
            vectors++; if (ic.err !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_read_ok_err[%0d]: got %b want 0", a, ic.err); end
        end
        ic.raddr = 3'd6;
        tick();
        vectors++; if (ic.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_read_rvalid: got %b want 1", ic.rvalid); end
        vectors++; if (ic.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL oor_read_rdata: got %h want 00", ic.rdata); end
        vectors++; if (ic.err !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_read_err: got %b want 1", ic.err); end
        ic.we = 1'b1; ic.waddr = 3'd6; ic.raddr = 3'd7;
        tick();
        vectors++; if (ic.err !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_both_err: got %b want 1", ic.err); end
        ic.we = 1'b0; ic.re = 1'b0;
        tick();
        vectors++; if (ic.err !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_both_strobe: got %b want 0", ic.err); end
        vectors++; if (ic.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_rvalid_drop: got %b want 0", ic.rvalid); end
    endtask

    task automatic test_latency2;
        for (int i = 0; i < 4; i++) begin
            id.we = 1'b1; id.waddr = 3'(i); id.wdata = 8'(16 + i); id.wbe = 1'b1;
            tick();
        end
        id.we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            id.re = (c < 4);
            id.raddr = 3'(c);
            tick();
            vectors++; if (id.rvalid !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin miscompares++; $display("[TB] FAIL lat2_rvalid[%0d]: got %b want %b", c, id.rvalid, (c >= 1 && c <= 4)); end
            if (c >= 1) begin
                vectors++; if (id.rdata !== ((c <= 4) ? 8'(15 + c) : 8'h13)) begin miscompares++; $display("[TB] FAIL lat2_rdata[%0d]: got %h want %h", c, id.rdata, (c <= 4) ? 8'(15 + c) : 8'h13); end
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        ia.we = 1'b1; ia.waddr = 3'd0; ia.wdata = 8'h77; ia.wbe = 1'b1;
        tick();
        ia.waddr = 3'd4; ia.wdata = 8'h44;
        tick();
        ia.we = 1'b0; ia.re = 1'b1; ia.raddr = 3'd4;
        tick();
        vectors++; if (ia.rdata !== 8'h44) begin miscompares++; $display("[TB] FAIL pre_reset_rdata: got %h want 44", ia.rdata); end
        ia.re = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if (ia.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rvalid: got %b want 0", ia.rvalid); end
        vectors++; if (ia.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL async_busy: got %b want 1", ia.busy); end
        vectors++; if (ia.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL async_rdata: got %h want 00", ia.rdata); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        vectors++; if (ia.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_clear_busy: got %b want 1", ia.busy); end
        vectors++; if (ia.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_clear_rvalid: got %b want 0", ia.rvalid); end
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (ia.busy !== 1'b1) break;
            cnt++;
            vectors++; if (ia.rvalid !== 1'b0 || ia.err !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_strobes[%0d]: got rvalid=%b err=%b want 0 0", c, ia.rvalid, ia.err); end
            ia.we = 1'b1; ia.waddr = 3'(c); ia.wdata = 8'hEE; ia.wbe = 1'b1;
            ia.re = 1'b1; ia.raddr = 3'(c);
            tick();
        end
        ia.we = 1'b0; ia.re = 1'b0;
        vectors++; if (cnt !== 8) begin miscompares++; $display("[TB] FAIL restart_cycles: got %0d want 8", cnt); end
        for (int a = 0; a < 8; a++) begin
            ia.re = 1'b1;
            ia.raddr = 3'(a);
            tick();
            vectors++; if (ia.rdata !== 8'h00 || ia.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL recleared[%0d]: got %h/%b want 00/1", a, ia.rdata, ia.rvalid); end
        end
        ia.re = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_byte_enable();
        test_rdw_read_first();
        test_rdw_write_first();
        test_out_of_range();
        test_latency2();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
